seq_square: RTL and testbench
=============================

// Module: seq_square
// PURPOSE
//  Parametrised, multi-cycle squarer: dout = din*din for WIDTH-bit unsigned din.
//  Uses an iterative shift-add datapath (one multiplier bit per cycle) with
//  valid/ready handshakes on both sides. Replaces the 4-bit LUT squarer where
//  wider operands would make a LUT or single-cycle multiplier too large.
// PARAMETERS
//  WIDTH       8   operand width in bits (>=2); result is 2*WIDTH bits
//  EARLY_EXIT  0   1: leave CALC as soon as the remaining multiplier bits are all zero
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          din is valid
//  in_ready   out  1          block can accept an operand (high only in IDLE)
//  din        in   WIDTH      unsigned operand
//  out_valid  out  1          dout holds a finished result
//  out_ready  in   1          consumer accepts dout
//  dout       out  2*WIDTH    din*din, unsigned
//  busy       out  1          high in CALC or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready=1, out_valid=0, busy=0, dout=0,
//   internal acc/mcand/mult/cnt=0. Reset mid-CALC or mid-DONE aborts; result is lost.
//  FSM states: IDLE, CALC, DONE.
//  IDLE: in_ready=1. On in_valid&in_ready: mcand<=din, mult<=din, acc<=0, cnt<=0 -> CALC.
//  CALC: in_ready=0. Each cycle: if mult[0], acc<=acc+(mcand<<cnt); mult<=mult>>1;
//   cnt<=cnt+1. Exit to DONE after the cycle where cnt==WIDTH-1, or, if EARLY_EXIT=1,
//   after the first cycle where (mult>>1)==0.
//  DONE: out_valid=1, dout=acc (registered, stable while out_valid=1 and out_ready=0).
//   On out_ready: out_valid<=0 -> IDLE. dout retains its last value after the handshake.
//  Latency: out_valid rises exactly WIDTH cycles after the accept edge (EARLY_EXIT=0);
//   with EARLY_EXIT=1, 1..WIDTH cycles (din=0 or 1 -> 1 cycle).
//  Throughput: at most one operand per WIDTH+2 cycles; no operand accepted in DONE.
//  Widths: acc is 2*WIDTH bits; the shifted partial product is zero-extended to 2*WIDTH;
//   no overflow possible ((2^WIDTH-1)^2 < 2^(2*WIDTH)). cnt is $clog2(WIDTH) bits.
//  in_valid while not in IDLE is ignored (no queuing); din only sampled on accept.
//  out_ready while out_valid=0 has no effect.
//  Illegal state encoding recovers to IDLE on the next clock.
// STRUCTURE
//  Shared package seq_arith_pkg: FSM state typedef/localparams (S_IDLE, S_CALC, S_DONE),
//   reused by later sequential arithmetic blocks.
//  One natural sub-module: square_step (combinational: acc, mcand, mult[0], cnt ->
//   next acc); FSM, counters and handshake stay in seq_square.
// TESTING
//  WIDTH=4: din=15 accepted, out_ready=1 -> out_valid exactly 4 cycles later, dout=225.
//  WIDTH=4: sweep din=0..15 back to back -> dout=din*din for each; compare with the old
//   case-table squarer; in_ready low throughout CALC/DONE.
//  WIDTH=8: din=255 -> dout=65025; din=128 -> 16384; out_ready low 3 cycles -> dout and
//   out_valid held, then one handshake, in_ready high next cycle.
//  WIDTH=8, EARLY_EXIT=1: din=1 -> dout=1 after 1 cycle; din=0 -> 0 after 1 cycle;
//   din=3 -> 9 after 2 cycles.
//  rst_n pulsed low mid-CALC (din=200) -> outputs at reset values immediately
//   (async); next operand din=7 -> dout=49 with normal latency.
//  in_valid held high during CALC with changing din -> ignored; result matches the
//   operand captured at accept.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// seq_square uses the FSM state encoding below; later blocks are expected to reuse it.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_square_if.sv
// Operand/result handshake bundle for seq_square.
// The master side drives operands and consumes results; the slave side is the squarer.
interface seq_square_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   din;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] dout;
  logic               busy;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/seq_square_step.sv
// One shift-add iteration: adds the multiplicand, shifted by the current bit
// position, into the accumulator when the current multiplier bit is set.
module square_step #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mult_lsb,
  input  logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [2*WIDTH-1:0] partial;

  // Zero-extend before shifting so no multiplicand bit is lost.
  assign partial  = {{WIDTH{1'b0}}, mcand} << cnt;
  assign acc_next = mult_lsb ? acc + partial : acc;
endmodule

// File: rtl/seq_square.sv
// Multi-cycle unsigned squarer: dout = din*din, one multiplier bit per cycle,
// with valid/ready handshakes on operand and result sides.
module seq_square
  import seq_arith_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_square_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             state_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mult_reg;
  logic [CW-1:0]      cnt_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               calc_last;

  square_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc      (acc_reg),
    .mcand    (mcand_reg),
    .mult_lsb (mult_reg[0]),
    .cnt      (cnt_reg),
    .acc_next (acc_next)
  );

  // Early exit fires once no set multiplier bits remain above the current one.
  assign calc_last = (cnt_reg == LAST_CNT) ||
                     (EARLY_EXIT && (mult_reg[WIDTH-1:1] == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mult_reg      <= '0;
      cnt_reg       <= '0;
      dout_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_reg    <= bus.din;
            mult_reg     <= bus.din;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_reg  <= acc_next;
          mult_reg <= mult_reg >> 1;
          cnt_reg  <= cnt_reg + CW'(1);
          if (calc_last) begin
            dout_reg      <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.dout      = dout_reg;
endmodule

// File: tb/tb_seq_square.sv
// Bench for seq_square: three instances (WIDTH=4, WIDTH=8, WIDTH=8 with early exit)
// driven one transaction at a time against a scoreboard of bench-computed squares.
module tb_seq_square;
  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  iv;
  logic [2:0]  orr;
  logic [15:0] dv [3];
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  bz;
  wire  [15:0] dq [3];

  int total = 0;
  int bad   = 0;
  logic [15:0] sbq [$];

  always #5 clk = ~clk;

  seq_square_if #(.WIDTH(4)) if4 ();
  seq_square_if #(.WIDTH(8)) if8 ();
  seq_square_if #(.WIDTH(8)) if8e ();

  seq_square #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_w4 (.clk(clk), .rst_n(rst_n[0]), .bus(if4));
  seq_square #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (.clk(clk), .rst_n(rst_n[1]), .bus(if8));
  seq_square #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (.clk(clk), .rst_n(rst_n[2]), .bus(if8e));

  assign if4.in_valid  = iv[0];
  assign if4.din       = dv[0][3:0];
  assign if4.out_ready = orr[0];
  assign ir[0]         = if4.in_ready;
  assign ov[0]         = if4.out_valid;
  assign bz[0]         = if4.busy;
  assign dq[0]         = {8'h00, if4.dout};

  assign if8.in_valid  = iv[1];
  assign if8.din       = dv[1][7:0];
  assign if8.out_ready = orr[1];
  assign ir[1]         = if8.in_ready;
  assign ov[1]         = if8.out_valid;
  assign bz[1]         = if8.busy;
  assign dq[1]         = if8.dout;

  assign if8e.in_valid  = iv[2];
  assign if8e.din       = dv[2][7:0];
  assign if8e.out_ready = orr[2];
  assign ir[2]          = if8e.in_ready;
  assign ov[2]          = if8e.out_valid;
  assign bz[2]          = if8e.busy;
  assign dq[2]          = if8e.dout;

  // Reference for the 4-bit case: the squarer table this block replaces.
  function automatic logic [15:0] sq_table(input logic [3:0] a);
    case (a)
      4'd0:  return 16'd0;    4'd1:  return 16'd1;
      4'd2:  return 16'd4;    4'd3:  return 16'd9;
      4'd4:  return 16'd16;   4'd5:  return 16'd25;
      4'd6:  return 16'd36;   4'd7:  return 16'd49;
      4'd8:  return 16'd64;   4'd9:  return 16'd81;
      4'd10: return 16'd100;  4'd11: return 16'd121;
      4'd12: return 16'd144;  4'd13: return 16'd169;
      4'd14: return 16'd196;  default: return 16'd225;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance k: accept, wait for result, optional
  // back-pressure, handshake. Noisy keeps in_valid high with changing din.
  task automatic xfer(input int k, input logic [15:0] d, input int lat,
                      input int hold, input bit noisy);
    logic [15:0] exp;
    int n;
    sbq.push_back(k == 0 ? sq_table(d[3:0]) : (d * d));
    n = 0;
    while (ir[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_idle", 32'(ir[k]), 1);
    iv[k] = 1'b1;
    dv[k] = d;
    tick();
    if (!noisy) iv[k] = 1'b0;
    n = 0;
    while (ov[k] !== 1'b1 && n < 40) begin
      chk("in_ready_low_calc", 32'(ir[k]), 0);
      chk("busy_calc", 32'(bz[k]), 1);
      if (noisy) dv[k] = 16'($urandom_range(0, 255));
      tick();
      n++;
    end
    iv[k] = 1'b0;
    chk("latency", n, lat);
    exp = sbq.pop_front();
    chk("dout", 32'(dq[k]), 32'(exp));
    chk("in_ready_low_done", 32'(ir[k]), 0);
    chk("busy_done", 32'(bz[k]), 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("out_valid_hold", 32'(ov[k]), 1);
      chk("dout_hold", 32'(dq[k]), 32'(exp));
    end
    orr[k] = 1'b1;
    tick();
    orr[k] = 1'b0;
    chk("out_valid_after_hs", 32'(ov[k]), 0);
    chk("in_ready_after_hs", 32'(ir[k]), 1);
    chk("dout_retained", 32'(dq[k]), 32'(exp));
    $display("xfer inst=%0d din=%0d dout=%0d latency=%0d", k, d, dq[k], n);
  endtask

  initial begin
    rst_n = 3'b000;
    iv    = 3'b000;
    orr   = 3'b000;
    for (int i = 0; i < 3; i++) dv[i] = 16'd0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 1);
      chk("rst_out_valid", 32'(ov[k]), 0);
      chk("rst_busy", 32'(bz[k]), 0);
      chk("rst_dout", 32'(dq[k]), 0);
    end
    rst_n = 3'b111;
    tick();

    // out_ready with nothing pending must not disturb IDLE
    orr[0] = 1'b1;
    tick();
    orr[0] = 1'b0;
    chk("idle_out_ready_ov", 32'(ov[0]), 0);
    chk("idle_out_ready_ir", 32'(ir[0]), 1);

    // WIDTH=4
    xfer(0, 16'd15, 4, 0, 1'b0);
    for (int i = 0; i < 16; i++) xfer(0, 16'(i), 4, 0, 1'b0);
    xfer(0, 16'd11, 4, 0, 1'b1);

    // WIDTH=8
    xfer(1, 16'd255, 8, 0, 1'b0);
    xfer(1, 16'd128, 8, 3, 1'b0);

    // Async reset mid-CALC aborts the operation
    sbq.push_back(16'd40000);
    iv[1] = 1'b1;
    dv[1] = 16'd200;
    tick();
    iv[1] = 1'b0;
    tick();
    tick();
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("arst_in_ready", 32'(ir[1]), 1);
    chk("arst_out_valid", 32'(ov[1]), 0);
    chk("arst_busy", 32'(bz[1]), 0);
    chk("arst_dout", 32'(dq[1]), 0);
    void'(sbq.pop_front());
    $display("xfer inst=1 din=200 aborted by reset");
    tick();
    rst_n[1] = 1'b1;
    tick();
    xfer(1, 16'd7, 8, 0, 1'b0);
    xfer(1, 16'd200, 8, 0, 1'b1);

    // WIDTH=8 with early exit
    xfer(2, 16'd1, 1, 0, 1'b0);
    xfer(2, 16'd0, 1, 0, 1'b0);
    xfer(2, 16'd3, 2, 0, 1'b0);
    xfer(2, 16'd5, 3, 0, 1'b0);
    xfer(2, 16'd128, 8, 0, 1'b0);
    xfer(2, 16'd255, 8, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
